// File: rtl/msi_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : msi_line_ctrl
// Purpose  : Per-line MSI state table with CPU hit/miss classification, bus
//            request/grant handshake and snoop application. The hit/miss
//            statistics counters exist only when MSI_LINE_CTRL_STATS_EN is
//            defined; otherwise hit_count and miss_count are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module msi_line_ctrl #(
    parameter int NUM_LINES = 4,
    parameter int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_valid,
    output logic             cpu_ready,
    input  logic             cpu_write,
    input  logic [IDX_W-1:0] cpu_index,
    output logic             cpu_done,
    output logic             cpu_hit,
    output logic             bus_req,
    output logic [1:0]       bus_cmd,
    output logic [IDX_W-1:0] bus_index,
    input  logic             bus_gnt,
    input  logic             snoop_valid,
    input  logic [1:0]       snoop_cmd,
    input  logic [IDX_W-1:0] snoop_index,
    output logic             wb_valid,
    output logic [IDX_W-1:0] wb_index,
    output logic [15:0]      hit_count,
    output logic [15:0]      miss_count
);

    localparam logic [0:0] c_idle        = 1'b0;
    localparam logic [0:0] c_bus         = 1'b1;
    localparam logic [1:0] c_invalid     = 2'b00;
    localparam logic [1:0] c_modified    = 2'b01;
    localparam logic [1:0] c_shared      = 2'b10;
    localparam logic [1:0] c_cmd_inval   = 2'b00;
    localparam logic [1:0] c_cmd_wr_miss = 2'b01;
    localparam logic [1:0] c_cmd_rd_miss = 2'b10;

    logic [1:0]       r_lines [NUM_LINES];
    logic [0:0]       r_state;
    logic [1:0]       r_cmd;
    logic [IDX_W-1:0] r_index;
    logic             r_write;

    logic             w_snoop_apply;
    logic [1:0]       w_snoop_old;
    logic [1:0]       w_snoop_new;
    logic [1:0]       w_cpu_line;
    logic             w_accept;
    logic             w_hit;
    logic [1:0]       w_miss_cmd;
    logic             w_grant;

    assign w_snoop_apply = snoop_valid && (snoop_cmd != 2'b11);
    assign w_snoop_old   = r_lines[snoop_index];
    assign w_snoop_new   = (snoop_cmd == c_cmd_rd_miss)
                         ? ((w_snoop_old == c_modified) ? c_shared : w_snoop_old)
                         : c_invalid;

    // Classification must see the line as a same-cycle snoop leaves it.
    assign w_cpu_line = (w_snoop_apply && (snoop_index == cpu_index))
                      ? w_snoop_new : r_lines[cpu_index];

    assign w_accept   = cpu_valid && cpu_ready;
    assign w_hit      = cpu_write ? (w_cpu_line == c_modified)
                                  : ((w_cpu_line == c_modified) || (w_cpu_line == c_shared));
    assign w_miss_cmd = cpu_write ? ((w_cpu_line == c_shared) ? c_cmd_inval : c_cmd_wr_miss)
                                  : c_cmd_rd_miss;
    assign w_grant    = (r_state == c_bus) && bus_gnt;

    assign cpu_ready = (r_state == c_idle);
    assign bus_req   = (r_state == c_bus);
    assign bus_cmd   = r_cmd;
    assign bus_index = r_index;

    // Snoop is applied first; a same-cycle commit to the same line overrides it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LINES; i++) r_lines[i] <= c_invalid;
        end else begin
            for (int i = 0; i < NUM_LINES; i++) begin
                if (w_snoop_apply && (snoop_index == IDX_W'(i)))
                    r_lines[i] <= w_snoop_new;
                if (w_grant && (r_index == IDX_W'(i)))
                    r_lines[i] <= r_write ? c_modified : c_shared;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_idle;
            r_cmd    <= c_cmd_inval;
            r_index  <= '0;
            r_write  <= 1'b0;
            cpu_done <= 1'b0;
            cpu_hit  <= 1'b0;
        end else begin
            cpu_done <= 1'b0;
            cpu_hit  <= 1'b0;
            if (r_state == c_idle) begin
                if (w_accept) begin
                    if (w_hit) begin
                        cpu_done <= 1'b1;
                        cpu_hit  <= 1'b1;
                    end else begin
                        r_state <= c_bus;
                        r_cmd   <= w_miss_cmd;
                        r_index <= cpu_index;
                        r_write <= cpu_write;
                    end
                end
            end else if (w_grant) begin
                r_state  <= c_idle;
                cpu_done <= 1'b1;
            end else if ((r_cmd == c_cmd_inval) && w_snoop_apply &&
                         (snoop_cmd != c_cmd_rd_miss) && (snoop_index == r_index)) begin
                // Our shared copy was stolen before grant: upgrade becomes a full write miss.
                r_cmd <= c_cmd_wr_miss;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_index <= '0;
        end else begin
            wb_valid <= w_snoop_apply && (w_snoop_old == c_modified);
            if (w_snoop_apply && (w_snoop_old == c_modified))
                wb_index <= snoop_index;
        end
    end

`ifdef MSI_LINE_CTRL_STATS_EN
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if ((r_state == c_idle) && w_accept && w_hit && (r_hit_count != 16'hFFFF))
                r_hit_count <= r_hit_count + 16'd1;
            if (w_grant && (r_miss_count != 16'hFFFF))
                r_miss_count <= r_miss_count + 16'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    assign hit_count  = 16'd0;
    assign miss_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_msi_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_msi_line_ctrl
// Purpose  : Directed self-checking bench for msi_line_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msi_line_ctrl;

    localparam logic [1:0] c_cmd_inval   = 2'b00;
    localparam logic [1:0] c_cmd_wr_miss = 2'b01;
    localparam logic [1:0] c_cmd_rd_miss = 2'b10;

`ifdef MSI_LINE_CTRL_STATS_EN
    localparam int c_exp_hits   = 3;
    localparam int c_exp_misses = 2;
`else
    localparam int c_exp_hits   = 0;
    localparam int c_exp_misses = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_valid;
    logic        cpu_ready;
    logic        cpu_write;
    logic [1:0]  cpu_index;
    logic        cpu_done;
    logic        cpu_hit;
    logic        bus_req;
    logic [1:0]  bus_cmd;
    logic [1:0]  bus_index;
    logic        bus_gnt;
    logic        snoop_valid;
    logic [1:0]  snoop_cmd;
    logic [1:0]  snoop_index;
    logic        wb_valid;
    logic [1:0]  wb_index;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    msi_line_ctrl #(.NUM_LINES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_write(cpu_write),
        .cpu_index(cpu_index), .cpu_done(cpu_done), .cpu_hit(cpu_hit),
        .bus_req(bus_req), .bus_cmd(bus_cmd), .bus_index(bus_index), .bus_gnt(bus_gnt),
        .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd), .snoop_index(snoop_index),
        .wb_valid(wb_valid), .wb_index(wb_index),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [1:0] idx);
        cpu_valid = 1'b1;
        cpu_write = wr;
        cpu_index = idx;
        tick();
        cpu_valid = 1'b0;
    endtask

    task automatic hit_access(input string tag, input logic wr, input logic [1:0] idx);
        issue(wr, idx);
        check({tag, "_done"}, cpu_done, 1);
        check({tag, "_hit"}, cpu_hit, 1);
        check({tag, "_noreq"}, bus_req, 0);
        check({tag, "_ready"}, cpu_ready, 1);
    endtask

    task automatic grant(input string tag, input int wait_cycles, input logic [1:0] cmd);
        for (int i = 0; i < wait_cycles; i++) begin
            tick();
            check({tag, "_req_hold"}, bus_req, 1);
            check({tag, "_cmd_hold"}, bus_cmd, cmd);
            check({tag, "_nodone"}, cpu_done, 0);
        end
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        check({tag, "_done"}, cpu_done, 1);
        check({tag, "_hit0"}, cpu_hit, 0);
        check({tag, "_req_low"}, bus_req, 0);
        check({tag, "_ready"}, cpu_ready, 1);
    endtask

    task automatic miss_access(input string tag, input logic wr, input logic [1:0] idx,
                               input logic [1:0] cmd, input int wait_cycles);
        issue(wr, idx);
        check({tag, "_req"}, bus_req, 1);
        check({tag, "_cmd"}, bus_cmd, cmd);
        check({tag, "_idx"}, bus_index, idx);
        check({tag, "_notready"}, cpu_ready, 0);
        check({tag, "_nodone"}, cpu_done, 0);
        grant(tag, wait_cycles, cmd);
    endtask

    task automatic snoop(input logic [1:0] cmd, input logic [1:0] idx);
        snoop_valid = 1'b1;
        snoop_cmd   = cmd;
        snoop_index = idx;
        tick();
        snoop_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; cpu_valid = 1'b0; cpu_write = 1'b0; cpu_index = '0;
        bus_gnt = 1'b0; snoop_valid = 1'b0; snoop_cmd = '0; snoop_index = '0;
        tick(); tick();
        check("rst_ready", cpu_ready, 1);
        check("rst_req", bus_req, 0);
        check("rst_done", cpu_done, 0);
        check("rst_wb", wb_valid, 0);
        check("rst_cmd", bus_cmd, 0);
        check("rst_bidx", bus_index, 0);
        check("rst_hitcnt", hit_count, 0);
        rst_n = 1'b1;
        tick();

        // Read miss with a delayed grant, then a re-read hit.
        miss_access("rd2", 1'b0, 2'd2, c_cmd_rd_miss, 3);
        hit_access("rd2_again", 1'b0, 2'd2);

        // Grant while idle has no effect.
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        check("idle_gnt_done", cpu_done, 0);
        check("idle_gnt_req", bus_req, 0);

        // Upgrade of a shared line, minimum-latency grants.
        miss_access("rd1", 1'b0, 2'd1, c_cmd_rd_miss, 0);
        miss_access("wr1_up", 1'b1, 2'd1, c_cmd_inval, 0);
        hit_access("wr1_hit", 1'b1, 2'd1);

        // Snoops against a modified line.
        miss_access("wr3", 1'b1, 2'd3, c_cmd_wr_miss, 1);
        snoop(c_cmd_rd_miss, 2'd3);
        check("snp_rd_wb", wb_valid, 1);
        check("snp_rd_wbidx", wb_index, 3);
        hit_access("rd3_shared", 1'b0, 2'd3);
        snoop(c_cmd_wr_miss, 2'd3);
        check("snp_wr_nowb", wb_valid, 0);
        miss_access("rd3_inv", 1'b0, 2'd3, c_cmd_rd_miss, 0);

        // Pending upgrade loses its copy before grant.
        miss_access("rd0", 1'b0, 2'd0, c_cmd_rd_miss, 0);
        issue(1'b1, 2'd0);
        check("race_cmd0", bus_cmd, c_cmd_inval);
        snoop(c_cmd_wr_miss, 2'd0);
        check("race_cmd1", bus_cmd, c_cmd_wr_miss);
        check("race_req", bus_req, 1);
        check("race_nowb", wb_valid, 0);
        grant("race_gnt", 0, c_cmd_wr_miss);
        hit_access("wr0_hit", 1'b1, 2'd0);

        // Same-cycle snoop invalidation is seen by classification.
        snoop_valid = 1'b1; snoop_cmd = c_cmd_wr_miss; snoop_index = 2'd2;
        issue(1'b0, 2'd2);
        snoop_valid = 1'b0;
        check("byp_req", bus_req, 1);
        check("byp_cmd", bus_cmd, c_cmd_rd_miss);
        grant("byp_gnt", 0, c_cmd_rd_miss);

        // Reset while a transaction is pending.
        issue(1'b1, 2'd2);
        check("mid_req", bus_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_req", bus_req, 0);
        check("mid_rst_ready", cpu_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_nodone", cpu_done, 0);
            check("post_rst_noreq", bus_req, 0);
        end

        // Line 1 was modified before reset; now it must miss. Then 3 hits, 2 misses.
        miss_access("post_rd1", 1'b0, 2'd1, c_cmd_rd_miss, 0);
        hit_access("st_h1", 1'b0, 2'd1);
        hit_access("st_h2", 1'b0, 2'd1);
        hit_access("st_h3", 1'b0, 2'd1);
        miss_access("st_m2", 1'b1, 2'd1, c_cmd_inval, 0);
        check("hit_count", hit_count, c_exp_hits);
        check("miss_count", miss_count, c_exp_misses);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
